collapsering_harvester: RTL and testbench
=========================================

Name: collapsering_harvester

Overview:
- Multi-channel controller and entropy harvester for collapsing-ring oscillator macros.
- Each trial starts every enabled ring, lets it run and collapse, and counts ring edges through a synchronizer.
- Folds the count parities into one random bit per trial and packs the bits into words, or emits raw edge counts for characterisation.
- Sits between the ring macros and the register/FIFO interface. Output uses a valid/ready handshake.

Parameters:
- CHANNELS, 4, number of ring macros driven and sampled.
- DATA_W, 32, output word width.
- CNT_W, 16, width of the run_cycles and idle_cycles timers.
- EDGE_W, 8, width of each per-channel saturating edge counter (EDGE_W <= DATA_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run trials while high.
- mode  in  1  0 = packed bits, 1 = raw count.
- channel_mask  in  CHANNELS  channels included in a trial.
- run_cycles  in  CNT_W  clk cycles ring_start is held high.
- idle_cycles  in  CNT_W  clk cycles ring_start is held low after a run.
- ring_start  out  CHANNELS  start input to each ring macro.
- ring_clk  in  CHANNELS  ring clk_out, asynchronous to clk.
- out_data  out  DATA_W  harvested word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: ring_start=0, out_data=0, out_valid=0, busy=0, FSM=IDLE, shift register=0, bit count=0, all edge counters=0. Reset is asynchronous and can occur in any state.
- Synchronizer: each ring_clk passes through 2 flops, then a third flop for edge detection. A rising edge is counted when the synchronized value is 1 and the delayed value is 0. Ring edges faster than clk/2 are aliased; this is accepted as part of the entropy source.
- FSM states and transitions:
  - IDLE: go to ARM when enable=1 and out_valid=0.
  - ARM: ring_start = channel_mask (registered), held for max(run_cycles,1) cycles. Edge counters clear on ARM entry, then count.
  - SETTLE: ring_start=0 for max(idle_cycles,2) cycles. Counters keep counting to drain synchronizer latency.
  - HARVEST: 1 cycle. Computes the bit and the counts, then goes to IDLE if a word was produced, otherwise to ARM.
- Latency: ring_start rises on the first clk edge after the IDLE->ARM decision.
- Edge counters saturate at 2^EDGE_W-1 and never wrap.
- Harvest bit = XOR over masked channels of count[0]. If channel_mask=0, the bit is 0 and raw output is 0.
- Packed mode (mode=0):
  - The bit shifts into bit 0, existing bits shift left.
  - After DATA_W bits, out_data is loaded and out_valid is set on the next cycle; the bit count returns to 0.
- Raw mode (mode=1):
  - Every trial produces a word.
  - out_data = zero-extended count of the lowest-indexed channel set in channel_mask.
- Handshake:
  - out_valid stays high, and out_data stays stable, until a cycle with out_valid and out_ready both high. out_valid clears on the next edge.
  - No trial starts while out_valid=1, so back-pressure stalls only at word boundaries.
  - A new trial can start on the cycle after acceptance.
- enable low in ARM, SETTLE or HARVEST: abort. Next cycle ring_start=0 and FSM=IDLE; the partial shift register and bit count are cleared. A pending out_valid word is retained, not dropped.
- mode, channel_mask, run_cycles and idle_cycles are sampled on ARM entry and held for the whole trial. A mode change also clears the partial shift register.
- busy=1 in ARM, SETTLE and HARVEST.

Test Plan:
- CHANNELS=2, DATA_W=8, mask=2'b01, mode=0, ring model gives 3 edges per trial -> out_valid after 8 trials, out_data=8'hFF; ring_start pulse width equals run_cycles exactly.
- mask=2'b11, ch0 gives 3 edges, ch1 alternates 5/4 edges per trial -> bits alternate 0,1,... (starting 0) -> out_data=8'h55.
- mode=1, mask=2'b10, ch1 gives 5 edges -> out_data=5 each trial. ch1 gives 300 edges with EDGE_W=8 -> out_data=255 (saturated).
- Word pending, out_ready low for 50 cycles -> out_valid held and out_data stable, ring_start=0, busy=0. Raise out_ready -> valid clears next cycle, ring_start rises the cycle after.
- enable drops mid-ARM after 3 packed bits -> ring_start=0 next cycle, IDLE. Re-enable -> first word is built from 8 fresh bits; no stale bits appear.
- rst pulsed mid-SETTLE with out_valid=1 -> ring_start, out_valid and out_data go to 0 immediately, without waiting for a clk edge.
- run_cycles=0, idle_cycles=0 -> ARM lasts 1 cycle and SETTLE lasts 2 cycles.

Source files
------------

// File: rtl/collapsering_harvester.sv
// Purpose: drives collapsing-ring oscillator macros and harvests their edge counts as random bits or raw counts.
// Latency: ring_start rises one clk after the IDLE->ARM decision; a word appears one clk after its last HARVEST.
// Backpressure: out_valid/out_data hold until accepted; no new trial starts while a word is pending.
module collapsering_harvester #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16,
    parameter int EDGE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode,
    input  logic [CHANNELS-1:0] channel_mask,
    input  logic [CNT_W-1:0]    run_cycles,
    input  logic [CNT_W-1:0]    idle_cycles,
    output logic [CHANNELS-1:0] ring_start,
    input  logic [CHANNELS-1:0] ring_clk,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    localparam int BC_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, ARM, SETTLE, HARVEST} state_t;

    state_t              state;
    logic [CHANNELS-1:0] sync1, sync2, sync3, rise;
    logic [EDGE_W-1:0]   cnt [CHANNELS];
    logic [CNT_W-1:0]    timer, run_s, idle_s, run_last, settle_last;
    logic                mode_s;
    logic [CHANNELS-1:0] mask_s, parity;
    logic [DATA_W-1:0]   shreg, shift_next, raw_word;
    logic [BC_W-1:0]     bitcnt;
    logic                hbit, last_bit, counting, arm_entry;

    // Ring outputs are asynchronous: two flops for metastability, a third to detect rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= ring_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign counting = (state == ARM) || (state == SETTLE);

    // Phase lengths: ARM at least 1 cycle, SETTLE at least 2 so the synchronizer drains.
    assign run_last    = (run_s == '0) ? '0 : run_s - 1'b1;
    assign settle_last = (idle_s < CNT_W'(2)) ? CNT_W'(1) : idle_s - 1'b1;

    // Harvested bit, shifted word and raw count of the lowest-indexed masked channel.
    always_comb begin
        raw_word = '0;
        parity   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            parity[i] = cnt[i][0];
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_s[i]) begin
                raw_word               = '0;
                raw_word[EDGE_W-1:0]   = cnt[i];
            end
        end
    end

    assign hbit       = ^(parity & mask_s);
    assign shift_next = {shreg[DATA_W-2:0], hbit};
    assign last_bit   = (bitcnt == BC_W'(DATA_W - 1));

    // A trial starts from IDLE when no word is pending, or directly after a HARVEST that did not finish a word.
    assign arm_entry = enable && (((state == IDLE) && !out_valid) ||
                                  ((state == HARVEST) && !mode_s && !last_bit));

    // Per-channel saturating edge counters, cleared on every ARM entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (arm_entry)
                    cnt[i] <= '0;
                else if (counting && rise[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Trial sequencer, bit packer and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ring_start <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            timer      <= '0;
            mode_s     <= 1'b0;
            mask_s     <= '0;
            run_s      <= '0;
            idle_s     <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if ((state != IDLE) && !enable) begin
                // Abort: drop the partial word but keep any pending output word.
                state      <= IDLE;
                ring_start <= '0;
                shreg      <= '0;
                bitcnt     <= '0;
                timer      <= '0;
            end else begin
                case (state)
                    ARM: begin
                        if (timer == run_last) begin
                            state      <= SETTLE;
                            ring_start <= '0;
                            timer      <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (timer == settle_last) begin
                            state <= HARVEST;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    HARVEST: begin
                        if (mode_s) begin
                            out_data  <= raw_word;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            shreg <= shift_next;
                            if (last_bit) begin
                                out_data  <= shift_next;
                                out_valid <= 1'b1;
                                bitcnt    <= '0;
                                state     <= IDLE;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase

                if (arm_entry) begin
                    state      <= ARM;
                    ring_start <= channel_mask;
                    timer      <= '0;
                    mode_s     <= mode;
                    mask_s     <= channel_mask;
                    run_s      <= run_cycles;
                    idle_s     <= idle_cycles;
                    if (mode != mode_s) begin
                        shreg  <= '0;
                        bitcnt <= '0;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_collapsering_harvester.sv
module tb_collapsering_harvester;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  channel_mask = 2'b00;
    logic [15:0] run_cycles = 16'd20;
    logic [15:0] idle_cycles = 16'd10;
    logic [1:0]  ring_start;
    logic [1:0]  ring_clk;
    logic        rc0 = 1'b0;
    logic        rc1 = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;

    assign ring_clk = {rc1, rc0};

    collapsering_harvester #(
        .CHANNELS(2), .DATA_W(8), .CNT_W(16), .EDGE_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .channel_mask(channel_mask), .run_cycles(run_cycles), .idle_cycles(idle_cycles),
        .ring_start(ring_start), .ring_clk(ring_clk),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    int n0 = 3;
    int n1 = 5;
    bit alt_en = 1'b0;
    int alt_base = 0;
    int ch1_trials = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Ring models: a burst of slow pulses (24 ns period) after each ring_start rise.
    always begin
        @(posedge ring_start[0]);
        for (int k = 0; k < n0; k++) begin
            rc0 = 1'b1; #12;
            rc0 = 1'b0; #12;
        end
    end

    always begin
        int n;
        @(posedge ring_start[1]);
        n = alt_en ? ((((ch1_trials - alt_base) % 2) == 0) ? 5 : 4) : n1;
        ch1_trials++;
        for (int k = 0; k < n; k++) begin
            rc1 = 1'b1; #12;
            rc1 = 1'b0; #12;
        end
    end

    // Monitor: every accepted word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got=%0h expected=none", out_data);
            end else begin
                check("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rise_width(input int ch, output int w);
        int n = 0;
        while (ring_start[ch] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        w = 0;
        while (ring_start[ch] === 1'b1 && w < 3000) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic low_gap(input int ch, output int g);
        g = 0;
        while (ring_start[ch] !== 1'b1 && g < 3000) begin
            g++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, g, viol, rises, n;
        logic prev;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ring_start", ring_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Packed, ch0 odd count every trial -> all ones
        mode = 1'b0; channel_mask = 2'b01; n0 = 3;
        exp_q.push_back(8'hFF);
        enable = 1'b1;
        rise_width(0, w);
        check("t1_pulse_width", w, 20);
        wait_empty(3000, "t1_word_done");
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Packed, two channels, ch1 alternates 5/4 -> 0101_0101
        channel_mask = 2'b11; alt_base = ch1_trials; alt_en = 1'b1;
        exp_q.push_back(8'h55);
        enable = 1'b1;
        wait_empty(3000, "t2_word_done");
        enable = 1'b0; alt_en = 1'b0;
        repeat (5) @(negedge clk);

        // Raw mode, ch1 only
        mode = 1'b1; channel_mask = 2'b10; n1 = 5;
        exp_q.push_back(8'd5); exp_q.push_back(8'd5); exp_q.push_back(8'd5);
        enable = 1'b1;
        wait_empty(3000, "t3_raw_done");
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Raw mode, saturation at 255
        run_cycles = 16'd750; idle_cycles = 16'd20; n1 = 300;
        exp_q.push_back(8'd255);
        enable = 1'b1;
        wait_empty(2000, "t3_sat_done");
        enable = 1'b0;
        run_cycles = 16'd20; idle_cycles = 16'd10; n1 = 5;
        repeat (40) @(negedge clk);

        // Back-pressure: word held for 50 cycles, no new trial
        out_ready = 1'b0;
        enable = 1'b1;
        wait_valid(500);
        check("t4_valid_seen", out_valid, 1);
        check("t4_data", out_data, 5);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'd5 || ring_start !== 2'b00 || busy !== 1'b0)
                viol++;
        end
        check("t4_hold_violations", viol, 0);
        exp_q.push_back(8'd5);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_cleared", out_valid, 0);
        check("t4_no_start_yet", ring_start, 0);
        @(negedge clk);
        check("t4_start_after", ring_start, 2'b10);
        enable = 1'b0;
        @(negedge clk);
        check("t4_abort_ring_start", ring_start, 0);
        check("t4_abort_busy", busy, 0);
        repeat (30) @(negedge clk);

        // Abort after 3 packed bits, then a fresh word with no stale bits
        mode = 1'b0; channel_mask = 2'b01; n0 = 3;
        enable = 1'b1;
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 4 && n < 3000) begin
            @(negedge clk);
            if (ring_start[0] === 1'b1 && prev === 1'b0) rises++;
            prev = ring_start[0];
            n++;
        end
        check("t5_trials_started", rises, 4);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_abort_ring_start", ring_start, 0);
        check("t5_abort_busy", busy, 0);
        repeat (30) @(negedge clk);
        channel_mask = 2'b11; alt_base = ch1_trials; alt_en = 1'b1;
        exp_q.push_back(8'h55);
        enable = 1'b1;
        wait_empty(3000, "t5_fresh_word_done");
        enable = 1'b0; alt_en = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset with a pending word
        out_ready = 1'b0; mode = 1'b1; channel_mask = 2'b10; n1 = 5;
        enable = 1'b1;
        wait_valid(500);
        check("t6_pending_data", out_data, 5);
        enable = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset while a ring is being driven
        enable = 1'b1;
        wait_valid(0);
        n = 0;
        while (ring_start[1] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_ring_start", ring_start, 0);
        check("t6_rst_busy", busy, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Zero timers: ARM 1 cycle, SETTLE 2 cycles (+1 HARVEST before next ARM)
        mode = 1'b0; channel_mask = 2'b01; n0 = 0;
        run_cycles = 16'd0; idle_cycles = 16'd0;
        enable = 1'b1;
        rise_width(0, w);
        check("t7_arm_width", w, 1);
        low_gap(0, g);
        check("t7_low_gap", g, 3);
        enable = 1'b0;
        repeat (10) @(negedge clk);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
